// File: rtl/cu_pkg.sv
// Shared types and encodings for the hardwired control unit.
// Imported by the sequencer top and its output decoder.
package cu_pkg;

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_FETCH_L = 3'd1,
    S_FETCH_H = 3'd2,
    S_DECODE  = 3'd3,
    S_EXEC0   = 3'd4,
    S_EXEC1   = 3'd5,
    S_HALT    = 3'd6
  } state_t;

  localparam logic [3:0] OP_LDI = 4'h0;
  localparam logic [3:0] OP_LD  = 4'h1;
  localparam logic [3:0] OP_ST  = 4'h2;
  localparam logic [3:0] OP_MOV = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_LSL = 4'h9;
  localparam logic [3:0] OP_LSR = 4'hA;
  localparam logic [3:0] OP_INC = 4'hB;
  localparam logic [3:0] OP_DEC = 4'hC;
  localparam logic [3:0] OP_BRA = 4'hD;
  localparam logic [3:0] OP_BEQ = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [3:0] ALU_PASS = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0101;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_XOR  = 4'b1010;
  localparam logic [3:0] ALU_LSL  = 4'b1011;
  localparam logic [3:0] ALU_LSR  = 4'b1100;

  localparam logic [1:0] FS_CLR  = 2'b00;
  localparam logic [1:0] FS_LOAD = 2'b01;
  localparam logic [1:0] FS_DEC  = 2'b10;
  localparam logic [1:0] FS_INC  = 2'b11;

  localparam logic [1:0] MUX_ALU = 2'b00;
  localparam logic [1:0] MUX_MEM = 2'b01;
  localparam logic [1:0] MUX_IMM = 2'b10;
  localparam logic [1:0] MUX_ARF = 2'b11;

  localparam logic MUXC_RF  = 1'b0;
  localparam logic MUXC_ARF = 1'b1;

  localparam logic [1:0] ARF_AR = 2'd0;
  localparam logic [1:0] ARF_PC = 2'd3;

  localparam logic [3:0] EN_AR = 4'b1000;
  localparam logic [3:0] EN_PC = 4'b0001;

  function automatic logic [3:0] rf_en(input logic [1:0] f);
    return 4'b1000 >> f;
  endfunction

  function automatic logic [2:0] rf_rd(input logic [1:0] f);
    return {1'b1, f};
  endfunction

  function automatic logic [3:0] alu_of(input logic [3:0] op);
    logic [3:0] a;
    a = ALU_PASS;
    case (op)
      OP_ADD:  a = ALU_ADD;
      OP_SUB:  a = ALU_SUB;
      OP_AND:  a = ALU_AND;
      OP_OR:   a = ALU_OR;
      OP_XOR:  a = ALU_XOR;
      OP_LSL:  a = ALU_LSL;
      OP_LSR:  a = ALU_LSR;
      default: a = ALU_PASS;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational map from {state, IR, flags} to every
// datapath control input of the system block.
module cu_decode
  import cu_pkg::*;
(
  input  logic [2:0]  state,
  input  logic [15:0] ir,
  input  logic [3:0]  flags,
  output logic [1:0]  outasel,
  output logic [1:0]  outbsel,
  output logic [1:0]  funsel_IR,
  output logic [1:0]  funsel_arf,
  output logic [1:0]  funsel_rf,
  output logic [3:0]  funsel_alu,
  output logic [3:0]  regsel_rf,
  output logic [3:0]  rf_tsel,
  output logic [3:0]  regsel_arf,
  output logic [2:0]  rf_o1sel,
  output logic [2:0]  rf_o2sel,
  output logic [1:0]  MUXSelA,
  output logic [1:0]  MUXSelB,
  output logic        MUXSelC,
  output logic        wrMEM,
  output logic        csMEM,
  output logic        IR_enable,
  output logic        IR_lh,
  output logic        halted
);

  state_t     st;
  logic [3:0] op;
  logic [1:0] rd;
  logic [1:0] rs;
  logic       unused;

  assign st     = state_t'(state);
  assign op     = ir[15:12];
  assign rd     = ir[11:10];
  assign rs     = ir[9:8];
  assign unused = ^{ir[7:0], flags[2:0]};

  always_comb begin
    outasel    = ARF_AR;
    outbsel    = ARF_AR;
    funsel_IR  = FS_CLR;
    funsel_arf = FS_CLR;
    funsel_rf  = FS_CLR;
    funsel_alu = ALU_PASS;
    regsel_rf  = 4'b0000;
    rf_tsel    = 4'b0000;
    regsel_arf = 4'b0000;
    rf_o1sel   = 3'd0;
    rf_o2sel   = 3'd0;
    MUXSelA    = MUX_ALU;
    MUXSelB    = MUX_ALU;
    MUXSelC    = MUXC_RF;
    wrMEM      = 1'b0;
    csMEM      = 1'b1;
    IR_enable  = 1'b0;
    IR_lh      = 1'b0;
    halted     = 1'b0;
    unique case (1'b1)
      st == S_INIT: begin
        regsel_arf = EN_PC;
        funsel_arf = FS_CLR;
      end
      st == S_FETCH_L,
      st == S_FETCH_H: begin
        outbsel    = ARF_PC;
        csMEM      = 1'b0;
        IR_enable  = 1'b1;
        funsel_IR  = FS_LOAD;
        IR_lh      = (st == S_FETCH_H);
        regsel_arf = EN_PC;
        funsel_arf = FS_INC;
      end
      st == S_EXEC0: begin
        unique case (op)
          OP_LDI: begin
            MUXSelA   = MUX_IMM;
            regsel_rf = rf_en(rd);
            funsel_rf = FS_LOAD;
          end
          OP_LD, OP_ST: begin
            MUXSelB    = MUX_IMM;
            regsel_arf = EN_AR;
            funsel_arf = FS_LOAD;
          end
          OP_MOV: begin
            rf_o1sel   = rf_rd(rs);
            funsel_alu = ALU_PASS;
            MUXSelC    = MUXC_RF;
            MUXSelA    = MUX_ALU;
            regsel_rf  = rf_en(rd);
            funsel_rf  = FS_LOAD;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            rf_o1sel   = rf_rd(rd);
            rf_o2sel   = rf_rd(rs);
            funsel_alu = alu_of(op);
            MUXSelA    = MUX_ALU;
            regsel_rf  = rf_en(rd);
            funsel_rf  = FS_LOAD;
          end
          OP_LSL, OP_LSR: begin
            rf_o1sel   = rf_rd(rd);
            funsel_alu = alu_of(op);
            MUXSelA    = MUX_ALU;
            regsel_rf  = rf_en(rd);
            funsel_rf  = FS_LOAD;
          end
          OP_INC, OP_DEC: begin
            regsel_rf = rf_en(rd);
            funsel_rf = (op == OP_INC) ? FS_INC : FS_DEC;
          end
          OP_BRA, OP_BEQ: begin
            // BEQ falls through to no write when Z is clear
            if (op == OP_BRA || flags[3]) begin
              MUXSelB    = MUX_IMM;
              regsel_arf = EN_PC;
              funsel_arf = FS_LOAD;
            end
          end
          OP_HLT: begin
          end
        endcase
      end
      st == S_EXEC1: begin
        outbsel = ARF_AR;
        csMEM   = 1'b0;
        if (op == OP_ST) begin
          wrMEM      = 1'b1;
          rf_o1sel   = rf_rd(rs);
          MUXSelC    = MUXC_RF;
          funsel_alu = ALU_PASS;
        end else begin
          MUXSelA   = MUX_MEM;
          regsel_rf = rf_en(rd);
          funsel_rf = FS_LOAD;
        end
      end
      st == S_HALT: begin
        halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer for the system
// datapath; holds the state register and next-state logic.
module control_unit
  import cu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] IR_out,
  input  logic [3:0]  flags,
  output logic [1:0]  outasel,
  output logic [1:0]  outbsel,
  output logic [1:0]  funsel_IR,
  output logic [1:0]  funsel_arf,
  output logic [1:0]  funsel_rf,
  output logic [3:0]  funsel_alu,
  output logic [3:0]  regsel_rf,
  output logic [3:0]  rf_tsel,
  output logic [3:0]  regsel_arf,
  output logic [2:0]  rf_o1sel,
  output logic [2:0]  rf_o2sel,
  output logic [1:0]  MUXSelA,
  output logic [1:0]  MUXSelB,
  output logic        MUXSelC,
  output logic        wrMEM,
  output logic        csMEM,
  output logic        IR_enable,
  output logic        IR_lh,
  output logic        halted,
  output logic [2:0]  state_out
);

  state_t     state;
  state_t     state_nx;
  logic [3:0] op;

  assign op        = IR_out[15:12];
  assign state_out = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_INIT;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = S_INIT;
    unique case (1'b1)
      state == S_INIT:    state_nx = S_FETCH_L;
      state == S_FETCH_L: state_nx = S_FETCH_H;
      state == S_FETCH_H: state_nx = S_DECODE;
      state == S_DECODE:  state_nx = S_EXEC0;
      state == S_EXEC0: begin
        if (op == OP_LD || op == OP_ST) state_nx = S_EXEC1;
        else if (op == OP_HLT)          state_nx = S_HALT;
        else                            state_nx = S_FETCH_L;
      end
      state == S_EXEC1:   state_nx = S_FETCH_L;
      state == S_HALT:    state_nx = S_HALT;
      default:            state_nx = S_INIT;
    endcase
  end

  cu_decode u_dec (
    .state      (state),
    .ir         (IR_out),
    .flags      (flags),
    .outasel    (outasel),
    .outbsel    (outbsel),
    .funsel_IR  (funsel_IR),
    .funsel_arf (funsel_arf),
    .funsel_rf  (funsel_rf),
    .funsel_alu (funsel_alu),
    .regsel_rf  (regsel_rf),
    .rf_tsel    (rf_tsel),
    .regsel_arf (regsel_arf),
    .rf_o1sel   (rf_o1sel),
    .rf_o2sel   (rf_o2sel),
    .MUXSelA    (MUXSelA),
    .MUXSelB    (MUXSelB),
    .MUXSelC    (MUXSelC),
    .wrMEM      (wrMEM),
    .csMEM      (csMEM),
    .IR_enable  (IR_enable),
    .IR_lh      (IR_lh),
    .halted     (halted)
  );

endmodule

// File: tb/tb_control_unit.sv
// Scenario bench for control_unit: expected output vectors are
// queued per cycle and compared against the DUT as it steps.
module tb_control_unit;
  import cu_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] IR_out;
  logic [3:0]  flags;
  logic [1:0]  outasel, outbsel, funsel_IR, funsel_arf, funsel_rf;
  logic [3:0]  funsel_alu, regsel_rf, rf_tsel, regsel_arf;
  logic [2:0]  rf_o1sel, rf_o2sel, state_out;
  logic [1:0]  MUXSelA, MUXSelB;
  logic        MUXSelC, wrMEM, csMEM, IR_enable, IR_lh, halted;

  always #5 clock = ~clock;

  control_unit dut (
    .clock(clock), .reset(reset), .IR_out(IR_out), .flags(flags),
    .outasel(outasel), .outbsel(outbsel), .funsel_IR(funsel_IR),
    .funsel_arf(funsel_arf), .funsel_rf(funsel_rf),
    .funsel_alu(funsel_alu), .regsel_rf(regsel_rf),
    .rf_tsel(rf_tsel), .regsel_arf(regsel_arf),
    .rf_o1sel(rf_o1sel), .rf_o2sel(rf_o2sel),
    .MUXSelA(MUXSelA), .MUXSelB(MUXSelB), .MUXSelC(MUXSelC),
    .wrMEM(wrMEM), .csMEM(csMEM), .IR_enable(IR_enable),
    .IR_lh(IR_lh), .halted(halted), .state_out(state_out)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] oa, ob, fir, farf, frf;
    logic [3:0] alu, rrf, tsel, rarf;
    logic [2:0] o1, o2;
    logic [1:0] ma, mb;
    logic       mc, wr, cs, ire, irlh, hlt;
  } exp_t;

  typedef struct {
    exp_t  v;
    string tag;
  } sb_t;

  sb_t sb[$];
  int  n_run  = 0;
  int  n_fail = 0;

  function automatic exp_t idle(input logic [2:0] st);
    exp_t e;
    e    = '0;
    e.st = st;
    e.cs = 1'b1;
    return e;
  endfunction

  function automatic exp_t init_exp();
    exp_t e;
    e      = idle(3'd0);
    e.rarf = 4'b0001;
    e.farf = 2'b00;
    return e;
  endfunction

  function automatic exp_t fetch_exp(input logic hi);
    exp_t e;
    e      = idle(hi ? 3'd2 : 3'd1);
    e.ob   = 2'd3;
    e.cs   = 1'b0;
    e.ire  = 1'b1;
    e.fir  = 2'b01;
    e.irlh = hi;
    e.rarf = 4'b0001;
    e.farf = 2'b11;
    return e;
  endfunction

  function automatic exp_t snap();
    exp_t g;
    g.st = state_out;    g.oa = outasel;    g.ob = outbsel;
    g.fir = funsel_IR;   g.farf = funsel_arf; g.frf = funsel_rf;
    g.alu = funsel_alu;  g.rrf = regsel_rf; g.tsel = rf_tsel;
    g.rarf = regsel_arf; g.o1 = rf_o1sel;   g.o2 = rf_o2sel;
    g.ma = MUXSelA;      g.mb = MUXSelB;    g.mc = MUXSelC;
    g.wr = wrMEM;        g.cs = csMEM;      g.ire = IR_enable;
    g.irlh = IR_lh;      g.hlt = halted;
    return g;
  endfunction

  task automatic push(input exp_t v, input string tag);
    sb_t s;
    s.v   = v;
    s.tag = tag;
    sb.push_back(s);
  endtask

  task automatic push_front_end(input string tag);
    push(fetch_exp(1'b0), {tag, "_fetch_l"});
    push(fetch_exp(1'b1), {tag, "_fetch_h"});
    push(idle(3'd3), {tag, "_decode"});
  endtask

  task automatic test_reset();
    exp_t e;
    reset  = 1'b1;
    IR_out = 16'h0000;
    flags  = 4'b0000;
    #1;
    e = init_exp();
    n_run++;
    if (snap() !== e) begin
      n_fail++;
      $display("FAIL reset_init: got %h want %h", snap(), e);
    end
    @(posedge clock); #1;
    n_run++;
    if (snap() !== e) begin
      n_fail++;
      $display("FAIL reset_hold: got %h want %h", snap(), e);
    end
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_ldi();
    exp_t e;
    sb_t  s;
    IR_out = 16'h0005;
    push_front_end("ldi");
    e = idle(3'd4);
    e.rrf = 4'b1000; e.ma = 2'b10; e.frf = 2'b01;
    push(e, "ldi_exec0");
    while (sb.size() > 0) begin
      s = sb.pop_front();
      n_run++;
      if (snap() !== s.v) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", s.tag, snap(), s.v);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_add();
    exp_t e;
    sb_t  s;
    IR_out = 16'h4100;
    push_front_end("add");
    e = idle(3'd4);
    e.o1 = 3'd4; e.o2 = 3'd5; e.alu = 4'b0100;
    e.ma = 2'b00; e.rrf = 4'b1000; e.frf = 2'b01;
    push(e, "add_exec0");
    while (sb.size() > 0) begin
      s = sb.pop_front();
      n_run++;
      if (snap() !== s.v) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", s.tag, snap(), s.v);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_alu_ops();
    logic [15:0] irs [9] = '{16'h5600, 16'h6C00, 16'h7B00, 16'h8000,
                             16'h9800, 16'hAC00, 16'h3B00, 16'hB400,
                             16'hCC00};
    logic [3:0]  alus[9] = '{4'b0101, 4'b0111, 4'b1000, 4'b1010,
                             4'b1011, 4'b1100, 4'b0000, 4'b0000,
                             4'b0000};
    logic [2:0]  o1s [9] = '{3'd5, 3'd7, 3'd6, 3'd4, 3'd6, 3'd7,
                             3'd7, 3'd0, 3'd0};
    logic [2:0]  o2s [9] = '{3'd6, 3'd4, 3'd7, 3'd4, 3'd0, 3'd0,
                             3'd0, 3'd0, 3'd0};
    logic [3:0]  rrfs[9] = '{4'b0100, 4'b0001, 4'b0010, 4'b1000,
                             4'b0010, 4'b0001, 4'b0010, 4'b0100,
                             4'b0001};
    logic [1:0]  frfs[9] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                             2'b01, 2'b01, 2'b11, 2'b10};
    exp_t e;
    sb_t  s;
    for (int i = 0; i < 9; i++) begin
      IR_out = irs[i];
      push_front_end($sformatf("op%0h", irs[i][15:12]));
      e = idle(3'd4);
      e.alu = alus[i]; e.o1 = o1s[i]; e.o2 = o2s[i];
      e.rrf = rrfs[i]; e.frf = frfs[i];
      push(e, $sformatf("op%0h_exec0", irs[i][15:12]));
      while (sb.size() > 0) begin
        s = sb.pop_front();
        n_run++;
        if (snap() !== s.v) begin
          n_fail++;
          $display("FAIL %s: got %h want %h", s.tag, snap(), s.v);
        end
        @(posedge clock); #1;
      end
    end
  endtask

  task automatic test_ld_st();
    exp_t e;
    sb_t  s;
    for (int k = 0; k < 2; k++) begin
      IR_out = (k == 0) ? 16'h2180 : 16'h1C40;
      push_front_end(k == 0 ? "st" : "ld");
      e = idle(3'd4);
      e.mb = 2'b10; e.rarf = 4'b1000; e.farf = 2'b01;
      push(e, k == 0 ? "st_exec0" : "ld_exec0");
      e = idle(3'd5);
      e.cs = 1'b0; e.ob = 2'd0;
      if (k == 0) begin
        e.wr = 1'b1; e.o1 = 3'd5; e.mc = 1'b0; e.alu = 4'b0000;
      end else begin
        e.ma = 2'b01; e.rrf = 4'b0001; e.frf = 2'b01;
      end
      push(e, k == 0 ? "st_exec1" : "ld_exec1");
      while (sb.size() > 0) begin
        s = sb.pop_front();
        n_run++;
        if (snap() !== s.v) begin
          n_fail++;
          $display("FAIL %s: got %h want %h", s.tag, snap(), s.v);
        end
        @(posedge clock); #1;
      end
    end
  endtask

  task automatic test_branch();
    logic [15:0] irs[4] = '{16'hD033, 16'hE020, 16'hE020, 16'hE020};
    logic [3:0]  fls[4] = '{4'b0000, 4'b0000, 4'b0111, 4'b1000};
    logic        tkn[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_t e;
    sb_t  s;
    for (int i = 0; i < 4; i++) begin
      IR_out = irs[i];
      flags  = fls[i];
      push_front_end($sformatf("br%0d", i));
      e = idle(3'd4);
      if (tkn[i]) begin
        e.mb = 2'b10; e.rarf = 4'b0001; e.farf = 2'b01;
      end
      push(e, $sformatf("br%0d_exec0", i));
      while (sb.size() > 0) begin
        s = sb.pop_front();
        n_run++;
        if (snap() !== s.v) begin
          n_fail++;
          $display("FAIL %s: got %h want %h", s.tag, snap(), s.v);
        end
        @(posedge clock); #1;
      end
    end
    flags = 4'b0000;
  endtask

  task automatic test_reset_mid_st();
    exp_t e;
    sb_t  s;
    IR_out = 16'h2180;
    push_front_end("rst_st");
    e = idle(3'd4);
    e.mb = 2'b10; e.rarf = 4'b1000; e.farf = 2'b01;
    push(e, "rst_st_exec0");
    while (sb.size() > 0) begin
      s = sb.pop_front();
      n_run++;
      if (snap() !== s.v) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", s.tag, snap(), s.v);
      end
      @(posedge clock); #1;
    end
    n_run++;
    if (state_out !== 3'd5 || wrMEM !== 1'b1 || csMEM !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_st_in_exec1: got st=%0d wr=%b cs=%b want 5 1 0",
               state_out, wrMEM, csMEM);
    end
    #2 reset = 1'b1;
    #1;
    e = init_exp();
    n_run++;
    if (snap() !== e) begin
      n_fail++;
      $display("FAIL rst_st_async: got %h want %h", snap(), e);
    end
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
    e = fetch_exp(1'b0);
    n_run++;
    if (snap() !== e) begin
      n_fail++;
      $display("FAIL rst_st_refetch: got %h want %h", snap(), e);
    end
  endtask

  task automatic test_halt();
    exp_t e;
    sb_t  s;
    IR_out = 16'hF000;
    push(fetch_exp(1'b1), "hlt_fetch_h");
    push(idle(3'd3), "hlt_decode");
    push(idle(3'd4), "hlt_exec0");
    e = idle(3'd6);
    e.hlt = 1'b1;
    for (int i = 0; i < 25; i++) push(e, $sformatf("hlt_c%0d", i));
    @(posedge clock); #1;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      n_run++;
      if (snap() !== s.v) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", s.tag, snap(), s.v);
      end
      @(posedge clock); #1;
    end
    reset = 1'b1;
    #1;
    e = init_exp();
    n_run++;
    if (snap() !== e) begin
      n_fail++;
      $display("FAIL hlt_reset: got %h want %h", snap(), e);
    end
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
    e = fetch_exp(1'b0);
    n_run++;
    if (snap() !== e) begin
      n_fail++;
      $display("FAIL hlt_refetch: got %h want %h", snap(), e);
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_add();
    test_alu_ops();
    test_ld_st();
    test_branch();
    test_reset_mid_st();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
